shift_issue_queue: RTL and testbench

Request-buffering stage directly upstream of the ALU left shifter. Accepts shift requests (operand plus 6-bit amount) over a valid/ready handshake and stores them in a small FIFO. Issues one request per cycle to the shifter through a registered output: `sh_data`, `sh_amount` and a `sh_load` strobe. The output is held stable while the downstream stage stalls.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_req_fifo.sv | 68 ++++++
 rtl/shift_issue_queue.sv | 119 +++++++++++
 tb/tb_shift_issue_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the shifter issue queue.
//               SHAMT_W   - shift amount width (0..63)
//               ALU_WIDTH - shifter datapath width
//               shift_req_t - one queued shift request {amount, data}
//               amt_ge_width() - 7-bit unsigned "amount >= width" compare
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int SHAMT_W   = 6;
  localparam int ALU_WIDTH = 32;

  typedef struct packed {
    logic [SHAMT_W-1:0]   amount;
    logic [ALU_WIDTH-1:0] data;
  } shift_req_t;

  // Compare is done one bit wider than the amount so that a width of 64
  // (not representable in SHAMT_W bits) still compares correctly.
  function automatic logic amt_ge_width(input logic [SHAMT_W-1:0] amt,
                                        input int unsigned        width);
    logic [SHAMT_W:0] w_ext;
    w_ext = (SHAMT_W + 1)'(width);
    return ({1'b0, amt} >= w_ext);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shift_req_fifo
// Description : Pointer-based request FIFO with wrap-bit full/empty detect.
// Ports       : clk, rst       - clock, async active-high reset
//               push_i/wdata_i - write request (ignored when full)
//               pop_i          - read request (ignored when empty)
//               rdata_o        - current head entry
//               full_o/empty_o - occupancy flags
//               count_o        - occupied entries (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_req_fifo #(
  parameter int DATA_W = 38,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              push_ok, pop_ok;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: the writer is a full lap ahead.
    full_o   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
               (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    // Power-of-two depth makes natural overflow wrap modulo 2*DEPTH.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    rdata_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
    count_o  = wr_ptr_q - rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_issue_queue
// Description : Buffers shift requests in a FIFO and issues one per cycle to
//               the left shifter through a registered, stall-holding output.
// Ports       : clk, rst                   - clock, async active-high reset
//               in_valid_i/in_ready_o      - request handshake
//               in_data_i/in_amount_i      - operand and shift amount
//               sh_load_o/sh_ready_i       - issue handshake to the shifter
//               sh_data_o/sh_amount_o      - issued operand and amount
//               sh_zero_o                  - issued amount >= WIDTH
//               count_o                    - FIFO occupancy (excl. output reg)
// Config      : SHIFT_ISSUE_CLAMP_EN - clamp issued amounts >= WIDTH to WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_queue
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_data_i,
  input  logic [SHAMT_W-1:0]     in_amount_i,
  output logic                   sh_load_o,
  input  logic                   sh_ready_i,
  output logic [WIDTH-1:0]       sh_data_o,
  output logic [SHAMT_W-1:0]     sh_amount_o,
  output logic                   sh_zero_o,
  output logic [$clog2(DEPTH):0] count_o
);

  typedef struct packed {
    logic [SHAMT_W-1:0] amount;
    logic [WIDTH-1:0]   data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t               wr_req, head_req;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               head_ge;

  logic               sh_load_q,   sh_load_d;
  logic [WIDTH-1:0]   sh_data_q,   sh_data_d;
  logic [SHAMT_W-1:0] sh_amount_q, sh_amount_d;
  logic               sh_zero_q,   sh_zero_d;

  shift_req_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wr_req),
    .pop_i   (pop),
    .rdata_o (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  always_comb begin
    // Depends only on FIFO state, so a full queue refuses a push even when
    // the output register drains in the same cycle.
    in_ready_o    = !fifo_full;
    push          = in_valid_i && in_ready_o;
    wr_req.amount = in_amount_i;
    wr_req.data   = in_data_i;

    // Output register takes a new entry when empty or being consumed; the
    // FIFO head is the only source, so a push into an empty FIFO waits a cycle.
    pop         = (!sh_load_q || sh_ready_i) && !fifo_empty;
    head_ge     = amt_ge_width(head_req.amount, WIDTH);

    sh_load_d   = sh_load_q;
    sh_data_d   = sh_data_q;
    sh_amount_d = sh_amount_q;
    sh_zero_d   = sh_zero_q;
    if (!sh_load_q || sh_ready_i) begin
      sh_load_d = !fifo_empty;
    end
    if (pop) begin
      sh_data_d = head_req.data;
      sh_zero_d = head_ge;
`ifdef SHIFT_ISSUE_CLAMP_EN
      sh_amount_d = head_ge ? SHAMT_W'(WIDTH) : head_req.amount;
`else
      sh_amount_d = head_req.amount;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_load_q   <= 1'b0;
      sh_data_q   <= '0;
      sh_amount_q <= '0;
      sh_zero_q   <= 1'b0;
    end else begin
      sh_load_q   <= sh_load_d;
      sh_data_q   <= sh_data_d;
      sh_amount_q <= sh_amount_d;
      sh_zero_q   <= sh_zero_d;
    end
  end

  assign sh_load_o   = sh_load_q;
  assign sh_data_o   = sh_data_q;
  assign sh_amount_o = sh_amount_q;
  assign sh_zero_o   = sh_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_issue_queue
// Description : Directed self-checking bench for shift_issue_queue.
//               Honours SHIFT_ISSUE_CLAMP_EN for the amount-boundary vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_issue_queue;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH-1:0]       in_data_i;
  logic [SHAMT_W-1:0]     in_amount_i;
  logic                   sh_load_o;
  logic                   sh_ready_i;
  logic [WIDTH-1:0]       sh_data_o;
  logic [SHAMT_W-1:0]     sh_amount_o;
  logic                   sh_zero_o;
  logic [$clog2(DEPTH):0] count_o;

  int checks   = 0;
  int failures = 0;

  shift_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_amount_i (in_amount_i),
    .sh_load_o   (sh_load_o),
    .sh_ready_i  (sh_ready_i),
    .sh_data_o   (sh_data_o),
    .sh_amount_o (sh_amount_o),
    .sh_zero_o   (sh_zero_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ld, input logic [WIDTH-1:0] d,
                         input logic [SHAMT_W-1:0] a, input logic z);
    chk({tag, ".load"},   64'(sh_load_o),   64'(ld));
    chk({tag, ".data"},   64'(sh_data_o),   64'(d));
    chk({tag, ".amount"}, 64'(sh_amount_o), 64'(a));
    chk({tag, ".zero"},   64'(sh_zero_o),   64'(z));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_out(tag, 1'b0, '0, '0, 1'b0);
    chk({tag, ".count"}, 64'(count_o),    64'd0);
    chk({tag, ".ready"}, 64'(in_ready_o), 64'd1);
  endtask

  initial begin
    int sent;
    int got;
    shift_req_t exp_req;

    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_amount_i = '0;
    sh_ready_i  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // ---------------- reset then single request ----------------
    chk_reset_state("reset");
    in_valid_i = 1'b1; in_data_i = 32'h0000_0001; in_amount_i = 6'd4;
    tick();
    in_valid_i = 1'b0;
    chk("single.count_after_push", 64'(count_o),   64'd1);
    chk("single.load_not_yet",     64'(sh_load_o), 64'd0);
    tick();
    chk_out("single.issue", 1'b1, 32'h1, 6'd4, 1'b0);
    chk("single.count_issued", 64'(count_o), 64'd0);
    tick();
    chk("single.drained", 64'(sh_load_o), 64'd0);

    // ---------------- fill with stall ----------------
    sh_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'h100 + 32'(i); in_amount_i = 6'(i);
      tick();
    end
    in_valid_i = 1'b0;
    chk("fill.ready_low", 64'(in_ready_o), 64'd0);
    chk("fill.count4",    64'(count_o),    64'd4);
    chk_out("fill.hold_r1", 1'b1, 32'h101, 6'd1, 1'b0);
    tick();
    chk_out("fill.still_r1", 1'b1, 32'h101, 6'd1, 1'b0);

    // ---------------- full plus simultaneous pop ----------------
    in_valid_i = 1'b1; in_data_i = 32'hBAD; in_amount_i = 6'd9;
    sh_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("fullpop.count3", 64'(count_o),    64'd3);
    chk("fullpop.ready",  64'(in_ready_o), 64'd1);
    chk_out("drain.r2", 1'b1, 32'h102, 6'd2, 1'b0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk_out($sformatf("drain.r%0d", i), 1'b1, 32'h100 + 32'(i), 6'(i), 1'b0);
      chk($sformatf("drain.count%0d", i), 64'(count_o), 64'(5 - i));
    end
    tick();
    chk("drain.no_refused_entry", 64'(sh_load_o), 64'd0);

    // ---------------- amount boundary ----------------
    in_valid_i = 1'b1; in_data_i = 32'hA; in_amount_i = 6'd31;
    tick();
    in_data_i = 32'hB; in_amount_i = 6'd32;
    tick();
    chk_out("bound.amt31", 1'b1, 32'hA, 6'd31, 1'b0);
    in_data_i = 32'hC; in_amount_i = 6'd63;
    tick();
    in_valid_i = 1'b0;
    chk_out("bound.amt32", 1'b1, 32'hB, 6'd32, 1'b1);
    tick();
`ifdef SHIFT_ISSUE_CLAMP_EN
    chk_out("bound.amt63", 1'b1, 32'hC, 6'd32, 1'b1);
`else
    chk_out("bound.amt63", 1'b1, 32'hC, 6'd63, 1'b1);
`endif
    tick();
    chk("bound.drained", 64'(sh_load_o), 64'd0);

    // ---------------- pointer wrap, toggling sh_ready ----------------
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      sh_ready_i  = cyc[0];
      in_valid_i  = (sent < 20);
      in_data_i   = 32'h5000 + 32'(sent);
      in_amount_i = 6'(sent);
      if (sh_load_o && sh_ready_i) begin
        exp_req.data   = 32'h5000 + 32'(got);
        exp_req.amount = 6'(got);
        chk($sformatf("wrap.data%0d", got),   64'(sh_data_o),   64'(exp_req.data));
        chk($sformatf("wrap.amount%0d", got), 64'(sh_amount_o), 64'(exp_req.amount));
        got++;
      end
      chk("wrap.count_bound", 64'(count_o <= 4), 64'd1);
      if (in_valid_i && in_ready_o) sent++;
      tick();
    end
    in_valid_i = 1'b0;
    chk("wrap.all_issued", 64'(got),       64'd20);
    chk("wrap.empty_load", 64'(sh_load_o), 64'd0);
    chk("wrap.empty_cnt",  64'(count_o),   64'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    sh_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'h7700 + 32'(i); in_amount_i = 6'd40;
      tick();
    end
    in_valid_i = 1'b0;
    chk("arst.pre_count", 64'(count_o),   64'd3);
    chk("arst.pre_load",  64'(sh_load_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("arst.async");
    #1;
    rst = 1'b0;
    sh_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("arst.quiet%0d", i), 64'(sh_load_o), 64'd0);
    end
    in_valid_i = 1'b1; in_data_i = 32'hFEED; in_amount_i = 6'd0;
    tick();
    in_valid_i = 1'b0;
    tick();
    chk_out("arst.new_req", 1'b1, 32'hFEED, 6'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
